// File: rtl/hex_display_ctrl_pkg.sv
// Shared seven-segment constants for the debug hex display.
// Segments are active-low, bit0=a .. bit6=g.
package hex_display_ctrl_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_key_debounce.sv
// Push-button conditioning: 2-flop synchronizer, level debouncer and
// one-cycle press pulse on an accepted 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    // Down-counter is loaded on the first differing cycle; reaching 1 means
    // this is the DEBOUNCE_CYCLES-th consecutive differing cycle.
    assign accept = (sync_2 != stable) && ((cnt == CNT_W'(1)) || (DEBOUNCE_CYCLES <= 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_2;
                cnt    <= '0;
                press  <= ~sync_2;
            end else if (cnt == '0) begin
                cnt <= CNT_W'(DEBOUNCE_CYCLES - 1);
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Debug hex display: selects one of CHANNELS debug words with a key,
// optionally freezes it with a second key, and drives seven-segment digits.
module hex_display_ctrl
    import hex_display_ctrl_pkg::*;
#(
    parameter int DIGITS          = 6,
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLANK_LZ        = 0
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [CHANNELS*DIGITS*4-1:0]                    debug_bus,
    input  logic                                            key_next_n,
    input  logic                                            key_hold_n,
    output logic [DIGITS*7-1:0]                             hex,
    output logic [((CHANNELS > 2) ? $clog2(CHANNELS) : 1)-1:0] chan_sel,
    output logic                                            hold_active
);

    localparam int CW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
    localparam int WW = DIGITS * 4;

    logic            next_pulse;
    logic            hold_pulse;
    logic [CW-1:0]   chan_nxt;
    logic [WW-1:0]   words [CHANNELS];
    logic [WW-1:0]   display_word;
    logic [DIGITS*7-1:0] hex_nxt;
    logic            seen;
    logic [3:0]      nib;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_next_n),
        .press   (next_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_hold_n),
        .press   (hold_pulse)
    );

    for (genvar k = 0; k < CHANNELS; k++) begin : g_words
        assign words[k] = debug_bus[k*WW +: WW];
    end

    always_comb begin
        chan_nxt = chan_sel;
        if (next_pulse) begin
            chan_nxt = (chan_sel == CW'(CHANNELS - 1)) ? '0 : chan_sel + CW'(1);
        end
    end

    // Any key pulse forces a (re)capture from the post-increment channel,
    // which covers both freeze entry and channel change while frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_sel     <= '0;
            hold_active  <= 1'b0;
            display_word <= '0;
        end else begin
            chan_sel <= chan_nxt;
            if (hold_pulse) begin
                hold_active <= ~hold_active;
            end
            if (!hold_active || hold_pulse || next_pulse) begin
                display_word <= words[chan_nxt];
            end
        end
    end

    always_comb begin
        hex_nxt = '0;
        seen    = 1'b0;
        nib     = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib  = display_word[d*4 +: 4];
            seen = seen | (nib != 4'h0);
            hex_nxt[d*7 +: 7] = (BLANK_LZ != 0 && !seen && d != 0) ? SEG_BLANK : hex_glyph(nib);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < DIGITS; d++) begin
                hex[d*7 +: 7] <= (BLANK_LZ != 0 && d != 0) ? SEG_BLANK : SEG_0;
            end
        end else begin
            hex <= hex_nxt;
        end
    end

endmodule
